// File: rtl/cache_write_buffer.sv
// cache_write_buffer: posted-write buffer between a cache memory-side master and main memory.
//
// Cache writebacks are queued in a DEPTH-entry FIFO and acknowledged without waiting on memory.
// The FIFO then drains in order on the memory master port. A cache read passes through to
// memory only once the FIFO is empty, which keeps write-then-read ordering intact.
//
// Optional build macro WBUF_FWD_EN:
//   A read whose address matches a pending entry is answered from the newest matching entry
//   (1-cycle latency, no memory read). Without it, every read waits for empty and goes to memory.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   avs_s0_*              slave port facing the cache (address/read/write/writedata/readdata/
//                         waitrequest)
//   avm_m0_*              master port facing memory (address/read/write/writedata/readdata/
//                         waitrequest)
//   wbuf_count            number of occupied FIFO entries
module cache_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      avs_s0_address,
  input  logic                   avs_s0_read,
  input  logic                   avs_s0_write,
  input  logic [DATA_W-1:0]      avs_s0_writedata,
  output logic [DATA_W-1:0]      avs_s0_readdata,
  output logic                   avs_s0_waitrequest,
  output logic [ADDR_W-1:0]      avm_m0_address,
  output logic                   avm_m0_read,
  output logic                   avm_m0_write,
  output logic [DATA_W-1:0]      avm_m0_writedata,
  input  logic [DATA_W-1:0]      avm_m0_readdata,
  input  logic                   avm_m0_waitrequest,
  output logic [$clog2(DEPTH):0] wbuf_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              full, empty, rd_req, push, drain, pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full   = (count_q == CntW'(DEPTH));
  assign empty  = (count_q == '0);
  // A simultaneous write wins; the read stays stalled.
  assign rd_req = avs_s0_read & ~avs_s0_write;
  assign push   = reset & (state_q == StIdle) & avs_s0_write & ~full;
  // READ is only ever entered with an empty FIFO, so draining continues through RESP.
  assign drain  = reset & (state_q != StRead) & ~empty;
  assign pop    = drain & ~avm_m0_waitrequest;

`ifdef WBUF_FWD_EN
  logic [PtrW-1:0] fwd_idx;

  // Scan oldest to newest so the last match left standing is the newest entry.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (addr_mem[fwd_idx] == avs_s0_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {{(CntW-1){1'b0}}, push} - {{(CntW-1){1'b0}}, pop};

    case (state_q)
      StIdle: begin
        if (rd_req) begin
          if (fwd_hit) begin
            rd_data_d = fwd_data;
            state_d   = StResp;
          end else if (empty) begin
            rd_addr_d = avs_s0_address;
            state_d   = StRead;
          end
        end
      end
      StRead: begin
        if (!avm_m0_waitrequest) begin
          rd_data_d = avm_m0_readdata;
          state_d   = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset: an entry is only visible while count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= avs_s0_address;
      data_mem[wr_ptr_q] <= avs_s0_writedata;
    end
  end

  // Outputs are forced to their idle values while reset is held, whatever the state holds.
  always_comb begin
    avs_s0_waitrequest = 1'b1;
    avs_s0_readdata    = '0;
    avm_m0_read        = 1'b0;
    avm_m0_write       = 1'b0;
    avm_m0_address     = '0;
    avm_m0_writedata   = '0;
    wbuf_count         = '0;
    if (reset) begin
      wbuf_count         = count_q;
      avs_s0_readdata    = rd_data_q;
      avs_s0_waitrequest = ~(push | (state_q == StResp));
      if (state_q == StRead) begin
        avm_m0_read    = 1'b1;
        avm_m0_address = rd_addr_q;
      end else if (drain) begin
        avm_m0_write     = 1'b1;
        avm_m0_address   = addr_mem[rd_ptr_q];
        avm_m0_writedata = data_mem[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Self-checking bench for cache_write_buffer (DEPTH=4). A behavioural memory slave serves the
// master port; a monitor keeps an in-order write queue and an architectural memory image,
// and checks every drain and every read response against them.
module tb_cache_write_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 32;

  logic                   clk;
  logic                   reset;
  logic [ADDR_W-1:0]      avs_s0_address;
  logic                   avs_s0_read;
  logic                   avs_s0_write;
  logic [DATA_W-1:0]      avs_s0_writedata;
  logic [DATA_W-1:0]      avs_s0_readdata;
  logic                   avs_s0_waitrequest;
  logic [ADDR_W-1:0]      avm_m0_address;
  logic                   avm_m0_read;
  logic                   avm_m0_write;
  logic [DATA_W-1:0]      avm_m0_writedata;
  logic [DATA_W-1:0]      avm_m0_readdata;
  logic                   avm_m0_waitrequest;
  logic [$clog2(DEPTH):0] wbuf_count;

  cache_write_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_s0_address    (avs_s0_address),
    .avs_s0_read       (avs_s0_read),
    .avs_s0_write      (avs_s0_write),
    .avs_s0_writedata  (avs_s0_writedata),
    .avs_s0_readdata   (avs_s0_readdata),
    .avs_s0_waitrequest(avs_s0_waitrequest),
    .avm_m0_address    (avm_m0_address),
    .avm_m0_read       (avm_m0_read),
    .avm_m0_write      (avm_m0_write),
    .avm_m0_writedata  (avm_m0_writedata),
    .avm_m0_readdata   (avm_m0_readdata),
    .avm_m0_waitrequest(avm_m0_waitrequest),
    .wbuf_count        (wbuf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Memory slave behaviour: wr_mode 0 = random stalls, 1 = always stall, 2 = never stall.
  // rd_wait < 0 picks 0..3 wait cycles per read at random.
  int wr_mode = 0;
  int rd_wait = -1;
  int slv_rd_left;

  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];  // architectural image (accepted writes)
  logic [DATA_W-1:0] slv_mem [logic [ADDR_W-1:0]];  // what memory actually holds
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W-1:0] exp_data_q [$];
  logic [DATA_W-1:0] exp_rd_q [$];
  logic              rd_pending;
`ifdef WBUF_FWD_EN
  logic              seen_avm_read;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] mem_init(input logic [ADDR_W-1:0] a);
    return {4'hC, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [DATA_W-1:0] slv_rd(input logic [ADDR_W-1:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : mem_init(a);
  endfunction

  // Memory slave: decides waitrequest/readdata shortly after each falling edge.
  initial begin
    avm_m0_waitrequest = 1'b1;
    avm_m0_readdata    = '0;
    slv_rd_left        = -1;
    forever begin
      @(negedge clk);
      #1;
      if (avm_m0_read) begin
        if (slv_rd_left < 0) slv_rd_left = (rd_wait < 0) ? int'($urandom_range(0, 3)) : rd_wait;
        if (slv_rd_left > 0) begin
          avm_m0_waitrequest = 1'b1;
          slv_rd_left--;
        end else begin
          avm_m0_waitrequest = 1'b0;
          avm_m0_readdata    = slv_rd(avm_m0_address);
          slv_rd_left        = -1;
        end
      end else begin
        slv_rd_left = -1;
        case (wr_mode)
          1:       avm_m0_waitrequest = 1'b1;
          2:       avm_m0_waitrequest = 1'b0;
          default: avm_m0_waitrequest = ($urandom_range(0, 3) == 0);
        endcase
      end
    end
  end

  // Monitor / scoreboard: samples 1 time unit before each rising edge.
  initial begin
    rd_pending = 1'b0;
`ifdef WBUF_FWD_EN
    seen_avm_read = 1'b0;
`endif
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        chk("rst_avs_waitrequest", 32'(avs_s0_waitrequest), 32'd1);
        chk("rst_avs_readdata", avs_s0_readdata, 32'd0);
        chk("rst_avm_read", 32'(avm_m0_read), 32'd0);
        chk("rst_avm_write", 32'(avm_m0_write), 32'd0);
        chk("rst_avm_address", 32'(avm_m0_address), 32'd0);
        chk("rst_avm_writedata", avm_m0_writedata, 32'd0);
        chk("rst_wbuf_count", 32'(wbuf_count), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_rd_q.delete();
        rd_pending = 1'b0;
        ref_mem    = slv_mem;  // discarded writes never reach memory
      end else begin
        chk("wbuf_count", 32'(wbuf_count), 32'(exp_addr_q.size()));
        chk("rd_wr_exclusive", 32'(avm_m0_read & avm_m0_write), 32'd0);
        if (avm_m0_read) chk("mem_read_only_when_empty", 32'(wbuf_count), 32'd0);
`ifdef WBUF_FWD_EN
        if (avm_m0_read) seen_avm_read = 1'b1;
`endif
        if (avs_s0_write && !avs_s0_waitrequest) begin
          ref_mem[avs_s0_address] = avs_s0_writedata;
          exp_addr_q.push_back(avs_s0_address);
          exp_data_q.push_back(avs_s0_writedata);
        end
        if (avs_s0_read && !avs_s0_write && !rd_pending) begin
          exp_rd_q.push_back(ref_rd(avs_s0_address));
          rd_pending = 1'b1;
        end
        if (avs_s0_read && !avs_s0_write && !avs_s0_waitrequest) begin
          if (exp_rd_q.size() > 0) begin
            chk("read_data", avs_s0_readdata, exp_rd_q.pop_front());
          end else begin
            chk("read_resp_unexpected", 32'(exp_rd_q.size()), 32'd1);
          end
          rd_pending = 1'b0;
        end
        if (avm_m0_write && !avm_m0_waitrequest) begin
          if (exp_addr_q.size() > 0) begin
            chk("drain_address", 32'(avm_m0_address), 32'(exp_addr_q.pop_front()));
            chk("drain_data", avm_m0_writedata, exp_data_q.pop_front());
          end else begin
            chk("drain_unexpected", 32'(exp_addr_q.size()), 32'd1);
          end
          slv_mem[avm_m0_address] = avm_m0_writedata;
        end
      end
    end
  end

  // All driver tasks start and end exactly on a falling edge.
  task automatic wait_accept(input string name, output int waits, output logic [31:0] rdata,
                             output logic [31:0] cnt);
    logic done;
    done  = 1'b0;
    waits = 0;
    rdata = '0;
    cnt   = '0;
    for (int c = 0; c < 1000; c++) begin
      #4;
      if (!avs_s0_waitrequest) begin
        done  = 1'b1;
        rdata = avs_s0_readdata;
        cnt   = 32'(wbuf_count);
      end else begin
        waits++;
      end
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_completes"}, 32'(done), 32'd1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          output int waits, output logic [31:0] cnt);
    logic [31:0] unused_rd;
    avs_s0_address   = a;
    avs_s0_writedata = d;
    avs_s0_write     = 1'b1;
    wait_accept("write", waits, unused_rd, cnt);
    avs_s0_write     = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                         output int waits);
    logic [31:0] unused_cnt;
    avs_s0_address = a;
    avs_s0_read    = 1'b1;
    wait_accept("read", waits, d, unused_cnt);
    avs_s0_read    = 1'b0;
  endtask

  task automatic wait_empty();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      #4;
      if (wbuf_count == 0) done = 1'b1;
      @(negedge clk);
      if (done) break;
    end
    chk("buffer_empties", 32'(done), 32'd1);
  endtask

  initial begin
    int          w;
    logic [31:0] d;
    logic [31:0] c;
    logic        seen;

    reset            = 1'b0;
    avs_s0_address   = 28'h000_0010;
    avs_s0_writedata = 32'h1111_2222;
    avs_s0_read      = 1'b0;
    avs_s0_write     = 1'b1;
    repeat (3) @(negedge clk);

    // Release with the write still held: it goes through at once.
    reset = 1'b1;
    do_write(28'h000_0010, 32'h1111_2222, w, c);
    chk("post_reset_write_zero_wait", 32'(w), 32'd0);
    wait_empty();

    // Fill with memory stalled, then release.
    wr_mode = 1;
    for (int i = 0; i < 4; i++) begin
      do_write(28'h000_0010 + 28'(i), $urandom, w, c);
      chk("fill_zero_wait", 32'(w), 32'd0);
    end
    avs_s0_address   = 28'h000_0014;
    avs_s0_writedata = 32'hF1F7_0005;
    avs_s0_write     = 1'b1;
    #4;
    chk("full_write_stalled", 32'(avs_s0_waitrequest), 32'd1);
    chk("full_count", 32'(wbuf_count), 32'd4);
    @(negedge clk);
    repeat (2) @(negedge clk);
    wr_mode = 2;
    wait_accept("fifth_write", w, d, c);
    avs_s0_write = 1'b0;
    wait_empty();

    // Continuous push+pop across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      do_write(28'h000_0020 + 28'(i), $urandom, w, c);
      chk("pushpop_zero_wait", 32'(w), 32'd0);
      if (i > 0) chk("pushpop_count", c, 32'd1);
    end
    wait_empty();

    // Read right behind a write to the same address.
    rd_wait = 2;
    do_write(28'h000_1000, 32'hDEAD_BEEF, w, c);
    do_read(28'h000_1000, d, w);
    chk("read_after_write_data", d, 32'hDEAD_BEEF);

    // Pass-through latency on an empty buffer: 2 + memory wait cycles.
    rd_wait = 0;
    do_read(28'h000_1004, d, w);
    chk("read_latency_0", 32'(w), 32'd2);
    rd_wait = 3;
    do_read(28'h000_1004, d, w);
    chk("read_latency_3", 32'(w), 32'd5);

`ifdef WBUF_FWD_EN
    wr_mode       = 1;
    seen_avm_read = 1'b0;
    do_write(28'h000_1000, 32'h0000_0001, w, c);
    do_write(28'h000_1000, 32'h0000_0002, w, c);
    do_read(28'h000_1000, d, w);
    chk("fwd_data_newest", d, 32'h0000_0002);
    chk("fwd_latency", 32'(w), 32'd1);
    chk("fwd_no_mem_read", 32'(seen_avm_read), 32'd0);
    wr_mode = 2;
    wait_empty();
`endif

    // Reset while the memory read is outstanding.
    rd_wait        = 20;
    avs_s0_address = 28'h000_1008;
    avs_s0_read    = 1'b1;
    seen           = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #4;
      if (avm_m0_read) seen = 1'b1;
      @(negedge clk);
      if (seen) break;
    end
    chk("mid_read_reached", 32'(seen), 32'd1);
    reset       = 1'b0;
    avs_s0_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #4;
    chk("after_reset_no_mem_read", 32'(avm_m0_read), 32'd0);
    chk("after_reset_no_response", 32'(avs_s0_waitrequest), 32'd1);
    @(negedge clk);
    rd_wait = -1;
    do_read(28'h000_1008, d, w);

    // Randomized traffic over a small address set so hits and repeats are common.
    wr_mode = 0;
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [ADDR_W-1:0] a;
      r = $urandom_range(0, 9);
      a = 28'h000_1000 + 28'($urandom_range(0, 5));
      if (r < 6) do_write(a, $urandom, w, c);
      else if (r < 9) do_read(a, d, w);
      else @(negedge clk);
    end
    wait_empty();
    repeat (2) @(negedge clk);
    chk("final_write_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("final_read_queue_empty", 32'(exp_rd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_write_buffer.md
# cache_write_buffer

Posted-write buffer between the cache's memory-side master port and main memory. Accepts cache writebacks into a small FIFO so the cache is released without waiting on memory, then drains them in order on its own memory master port. Reads from the cache pass through to memory only after the FIFO is empty, preserving write-then-read ordering. An optional build feature serves a read directly from the buffer when the address hits a pending write.

## Interface
Parameters:
- DEPTH, 4: buffer entries; power of two, 2..16.
- ADDR_W, 28: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; the buffer is in reset while reset==0 at a rising edge.
- avs_s0_address  in  ADDR_W  request address from the cache master.
- avs_s0_read  in  1  read request.
- avs_s0_write  in  1  write request.
- avs_s0_writedata  in  DATA_W  write data.
- avs_s0_readdata  out  DATA_W  read data; valid when avs_s0_waitrequest==0 with read held.
- avs_s0_waitrequest  out  1  stall to the cache.
- avm_m0_address  out  ADDR_W  memory address.
- avm_m0_read  out  1  memory read.
- avm_m0_write  out  1  memory write (drain).
- avm_m0_writedata  out  DATA_W  memory write data.
- avm_m0_readdata  in  DATA_W  memory read data; valid in the cycle avm_m0_read is held with avm_m0_waitrequest==0.
- avm_m0_waitrequest  in  1  memory stall.
- wbuf_count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- FIFO: DEPTH entries of {address, data}, write pointer, read pointer, count. No merging: repeated writes to one address occupy separate entries.
- Write accept: avs_s0_write && count<DEPTH drives avs_s0_waitrequest=0 combinationally; entry pushed at the edge. Write while full: waitrequest=1, nothing pushed.
- Drain: whenever count>0 and state is IDLE, avm_m0_write=1 with head address/data. Pop on the edge where avm_m0_waitrequest==0.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Simultaneous avs_s0_read and avs_s0_write: write has priority; read stays stalled.
- FSM states:
  - IDLE: a read with count==0 moves the FSM to READ. A read with count>0 keeps avs_s0_waitrequest=1 while draining continues.
  - READ: avm_m0_read=1, avm_m0_address=latched read address, avm_m0_write=0. On avm_m0_waitrequest==0, capture avm_m0_readdata and move to RESP.
  - RESP: avs_s0_waitrequest=0 and avs_s0_readdata=captured data for exactly one cycle, then IDLE.
- Writes are not accepted in READ or RESP. The cache cannot issue them while its read is stalled.
- Reset, including mid-drain or mid-read: FIFO contents are discarded, count=0, FSM=IDLE.
- Output values during reset: avs_s0_waitrequest=1, avs_s0_readdata=0, avm_m0_read=0, avm_m0_write=0, avm_m0_address=0, avm_m0_writedata=0, wbuf_count=0.

## Timing
- Write with free space: zero-wait. Accepted in the cycle presented.
- First drain of a write pushed at edge N: avm_m0_write is asserted in cycle N+1.
- Pass-through read on an empty buffer:
  - Request seen in cycle T; avm_m0_read is asserted in cycle T+1.
  - If memory responds with waitrequest==0 in cycle T+1+k, the cache sees waitrequest==0 in cycle T+2+k.
  - Minimum read latency is 2 cycles.
- Read behind pending writes: the READ state is entered on the first edge at which count==0.
- avm_m0_read and avm_m0_write are never asserted together.

## Configuration
- WBUF_FWD_EN defined:
  - A read in IDLE compares its address against all valid entries.
  - On a hit, the newest matching entry's data is latched and the FSM goes directly to RESP next cycle: 1-cycle latency, no memory read, draining unaffected.
  - On a miss, the read waits for empty as before.
- WBUF_FWD_EN undefined: no comparators; every read waits for the buffer to be empty and goes to memory.

## Test plan
- Reset: hold reset=0 for 2 cycles with avs_s0_write=1 -> avs_s0_waitrequest=1, wbuf_count=0, avm_m0_write=0. After release, the first write is accepted.
- Fill/backpressure:
  - Stimulus: avm_m0_waitrequest=1, 5 writes to 0x0000010..0x0000014, DEPTH=4.
  - Required: first 4 zero-wait, fifth stalled, wbuf_count=4.
  - Release waitrequest: drains in order 0x10..0x13, then the fifth write is accepted.
- Push+pop: continuous writes with avm_m0_waitrequest=0 -> wbuf_count stays 1 and drained addresses match the write order across pointer wrap.
- Read ordering:
  - Stimulus: write 0x0001000=0xDEADBEEF, then an immediate read of 0x0001000; memory model returns stored data with 2 wait cycles.
  - Without WBUF_FWD_EN: avm_m0_read is asserted only after the drain pop, and the cache reads 0xDEADBEEF.
- Forwarding (WBUF_FWD_EN, memory stalled):
  - Stimulus: write 0x0001000=0x1, then 0x0001000=0x2, then read 0x0001000.
  - Required: readdata=0x2 one cycle after the request, avm_m0_read never asserted.
- Reset mid-read: assert reset=0 while in READ -> next cycle avm_m0_read=0, FSM in IDLE, no response to the cache.
